// File: rtl/proc_mem_subsystem.sv
// Data memory for the single-cycle core with a streaming DMA engine.
// The DMA bulk-loads or dumps words, and the core is stalled while it runs.
`timescale 1ns/1ps
module proc_mem_subsystem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              core_stall,
  input  logic              dma_start,
  input  logic              dma_dir,
  input  logic [IDX_W-1:0]  dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP, S_DONE} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic                r_mValid;
  logic [DATA_W-1:0]   r_mData;
  logic                r_done;
  logic                r_addrErr;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_idle;
  logic                w_oor;
  logic [IDX_W-1:0]    w_idx;
  logic                w_coreWe;
  logic                w_dmaWe;
  logic [1:0]          w_unused;

  assign w_idle   = (r_state == S_IDLE);
  assign w_idx    = DataAdr[IDX_W+1:2];
  assign w_oor    = |DataAdr[ADDR_W-1:IDX_W+2];
  assign w_unused = DataAdr[1:0];
  assign w_coreWe = w_idle && MemWrite && !w_oor;
  assign w_dmaWe  = (r_state == S_LOAD) && s_valid;

  assign ReadData   = (w_idle && !w_oor) ? r_mem[w_idx] : '0;
  assign dma_busy   = !w_idle;
  assign core_stall = !w_idle;
  assign s_ready    = (r_state == S_LOAD);
  assign m_valid    = r_mValid;
  assign m_data     = r_mData;
  assign dma_done   = r_done;
  assign addr_err   = r_addrErr;

  // Storage has no reset so its contents survive a reset mid-transfer.
  always_ff @(posedge clk) begin
    if (w_coreWe) begin
      r_mem[w_idx] <= WriteData;
    end else if (w_dmaWe) begin
      r_mem[r_addr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_mValid  <= 1'b0;
      r_mData   <= '0;
      r_done    <= 1'b0;
      r_addrErr <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_idle && w_oor) begin
        r_addrErr <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (dma_start) begin
            r_addr   <= dma_base;
            r_remain <= dma_len;
            if (dma_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= dma_dir ? S_DUMP : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (s_valid) begin
            r_addr   <= r_addr + IDX_W'(1);
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == LEN_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          // r_remain counts words still to fetch; the last handshake happens once it is zero.
          if (!r_mValid || m_ready) begin
            if (r_remain != '0) begin
              r_mData  <= r_mem[r_addr];
              r_mValid <= 1'b1;
              r_addr   <= r_addr + IDX_W'(1);
              r_remain <= r_remain - LEN_W'(1);
            end else begin
              r_mValid <= 1'b0;
            end
            if (r_mValid && m_ready && (r_remain == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
